// File: rtl/term_ctrl_if.sv
// -----------------------------------------------------------------------------
// term_ctrl_if
// Bus bundle for term_ctrl: the CPU memory-mapped register port plus the
// write port toward the terminal character buffer.
//   CPU side     : ena, rw, addr, wdata (to controller), rdata (from controller)
//   Terminal side: term_ena, term_rw, term_addr, term_wdata (from controller)
// Modports:
//   slave  - the controller (receives CPU requests, drives terminal writes)
//   master - the CPU/environment (issues requests, observes terminal writes)
// -----------------------------------------------------------------------------
interface term_ctrl_if #(
    parameter int unsigned DW = 32
);
    logic          ena;
    logic          rw;
    logic [DW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] wdata;
    logic          term_ena;
    logic          term_rw;
    logic [DW-1:0] term_addr;
    logic [DW-1:0] term_wdata;

    modport slave (
        input  ena, rw, addr, wdata,
        output rdata, term_ena, term_rw, term_addr, term_wdata
    );

    modport master (
        output ena, rw, addr, wdata,
        input  rdata, term_ena, term_rw, term_addr, term_wdata
    );
endinterface

// File: rtl/term_ctrl.sv
// -----------------------------------------------------------------------------
// term_ctrl
// Character-stream terminal controller. Bytes pushed into the DATA register
// are interpreted against a cursor (printables, LF, CR, BS) and turned into
// cell writes on the terminal buffer port; line advance clears the new row,
// and a CTRL command clears the whole screen.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - term_ctrl_if.slave: CPU register port (ena/rw/addr/wdata/rdata)
//          and terminal write port (term_ena/term_rw/term_addr/term_wdata)
// Register map (addr[3:2]): 0 DATA, 1 STATUS {ovf,busy}, 2 CURSOR {row,col},
// 3 CTRL (bit0 = clear screen).
// -----------------------------------------------------------------------------
module term_ctrl #(
    parameter int unsigned COLS = 70,
    parameter int unsigned ROWS = 30
) (
    input  logic       clk,
    input  logic       rst,
    term_ctrl_if.slave bus
);
    localparam logic        MEM_WRITE = 1'b1;
    localparam int unsigned ROW_W     = $clog2(ROWS);
    localparam int unsigned COL_W     = $clog2(COLS + 1);
    localparam int unsigned PTR_W     = $clog2(COLS * ROWS);

    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
    localparam logic [PTR_W-1:0] PTR_COLS = PTR_W'(COLS);
    localparam logic [PTR_W-1:0] CNT_ROW  = PTR_W'(COLS - 1);
    localparam logic [PTR_W-1:0] CNT_ALL  = PTR_W'(COLS * ROWS - 1);
    localparam logic [31:0]      COLS_V   = 32'(COLS);
    localparam logic [7:0]       SPACE    = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        CLR_ROW,
        CLR_ALL
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;      // always row*COLS+col while IDLE
    logic [PTR_W-1:0] cnt_q, cnt_d;      // clear writes still to issue
    logic             wrap_q, wrap_d;    // PUT must be followed by a row clear
    logic             ovf_q, ovf_d;
    logic             tena_q, tena_d;
    logic [PTR_W-1:0] taddr_q, taddr_d;
    logic [7:0]       tchar_q, tchar_d;

    logic             busy;
    logic             wr;
    logic [1:0]       sel;
    logic [7:0]       byte_v;
    logic [ROW_W-1:0] next_row;
    logic [PTR_W-1:0] next_row_ptr;
    logic [ROW_W-1:0] ld_row;
    logic [COL_W-1:0] ld_col;
    logic             unused_bits;

    // Row base for a cursor load, built from shifted adds of the constant.
    function automatic logic [PTR_W-1:0] row_base(input logic [ROW_W-1:0] r);
        logic [PTR_W-1:0] acc;
        acc = '0;
        for (int unsigned b = 0; b < PTR_W; b++) begin
            if (COLS_V[b]) acc = acc + (PTR_W'(r) << b);
        end
        return acc;
    endfunction

    assign busy   = (state_q != IDLE);
    assign wr     = bus.ena && (bus.rw == MEM_WRITE);
    assign sel    = bus.addr[3:2];
    assign byte_v = bus.wdata[7:0];

    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0],
                           bus.wdata[31:21], bus.wdata[15:8]};

    // Start of the following row derived from the current pointer.
    assign next_row     = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
    assign next_row_ptr = (row_q == ROW_MAX) ? '0
                        : ptr_q - PTR_W'(col_q) + PTR_COLS;

    assign ld_row = (32'(bus.wdata[20:16]) > ROWS - 1) ? ROW_MAX
                                                        : ROW_W'(bus.wdata[20:16]);
    assign ld_col = (32'(bus.wdata[6:0]) > COLS - 1) ? COL_MAX
                                                      : COL_W'(bus.wdata[6:0]);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        ovf_d   = ovf_q;
        tena_d  = 1'b0;
        taddr_d = taddr_q;
        tchar_d = tchar_q;

        if (wr && sel == 2'd1) begin
            ovf_d = 1'b0;
        end else if (wr && busy) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (wr && sel == 2'd0) begin
                    if (byte_v >= 8'h20 && byte_v <= 8'h7E) begin
                        state_d = PUT;
                        tena_d  = 1'b1;
                        taddr_d = ptr_q;
                        tchar_d = byte_v;
                        if (col_q == COL_MAX) begin
                            col_d  = '0;
                            row_d  = next_row;
                            ptr_d  = next_row_ptr;
                            wrap_d = 1'b1;
                        end else begin
                            col_d  = col_q + COL_W'(1);
                            ptr_d  = ptr_q + PTR_W'(1);
                            wrap_d = 1'b0;
                        end
                    end else if (byte_v == 8'h0A) begin
                        state_d = CLR_ROW;
                        col_d   = '0;
                        row_d   = next_row;
                        ptr_d   = next_row_ptr;
                        tena_d  = 1'b1;
                        taddr_d = next_row_ptr;
                        tchar_d = SPACE;
                        cnt_d   = CNT_ROW;
                    end else if (byte_v == 8'h0D) begin
                        col_d = '0;
                        ptr_d = ptr_q - PTR_W'(col_q);
                    end else if (byte_v == 8'h08) begin
                        if (col_q != '0) begin
                            state_d = PUT;
                            col_d   = col_q - COL_W'(1);
                            ptr_d   = ptr_q - PTR_W'(1);
                            tena_d  = 1'b1;
                            taddr_d = ptr_q - PTR_W'(1);
                            tchar_d = SPACE;
                            wrap_d  = 1'b0;
                        end
                    end
                end else if (wr && sel == 2'd3) begin
                    if (bus.wdata[0]) begin
                        state_d = CLR_ALL;
                        tena_d  = 1'b1;
                        taddr_d = '0;
                        tchar_d = SPACE;
                        cnt_d   = CNT_ALL;
                    end
                end else if (wr && sel == 2'd2) begin
                    row_d = ld_row;
                    col_d = ld_col;
                    ptr_d = row_base(ld_row) + PTR_W'(ld_col);
                end
            end

            PUT: begin
                if (wrap_q) begin
                    // Cursor already points at the start of the new row.
                    state_d = CLR_ROW;
                    wrap_d  = 1'b0;
                    tena_d  = 1'b1;
                    taddr_d = ptr_q;
                    tchar_d = SPACE;
                    cnt_d   = CNT_ROW;
                end else begin
                    state_d = IDLE;
                end
            end

            CLR_ROW, CLR_ALL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tena_d  = 1'b1;
                    taddr_d = taddr_q + PTR_W'(1);
                    cnt_d   = cnt_q - PTR_W'(1);
                    // Home the cursor alongside the last screen-clear write.
                    if (state_q == CLR_ALL && cnt_q == PTR_W'(1)) begin
                        row_d = '0;
                        col_d = '0;
                        ptr_d = '0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tena_q  <= 1'b0;
            taddr_q <= '0;
            tchar_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            tena_q  <= tena_d;
            taddr_q <= taddr_d;
            tchar_q <= tchar_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        unique case (sel)
            2'd1:    bus.rdata = {30'b0, ovf_q, busy};
            2'd2:    bus.rdata = {16'(row_q), 16'(col_q)};
            default: bus.rdata = '0;
        endcase
    end

    assign bus.term_ena   = tena_q;
    assign bus.term_rw    = MEM_WRITE;
    assign bus.term_addr  = 32'(taddr_q);
    assign bus.term_wdata = {24'b0, tchar_q};

endmodule

// File: tb/tb_term_ctrl.sv
// -----------------------------------------------------------------------------
// tb_term_ctrl
// Directed bench for term_ctrl. Expected terminal writes are queued when a
// byte or command is issued; a separate monitor pops one entry per observed
// term_ena cycle and compares address/data. Register reads are checked
// in-line against hand-computed values.
// -----------------------------------------------------------------------------
module tb_term_ctrl;
    logic clk;
    logic rst;

    term_ctrl_if #(.DW(32)) bus ();

    term_ctrl #(.COLS(70), .ROWS(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          wcount   = 0;
    logic [63:0] sb[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    task automatic expect_wr(input int unsigned a, input logic [7:0] ch);
        sb.push_back({a[31:0], 24'b0, ch});
    endtask

    // Scoreboard monitor: every terminal write must match the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && bus.term_ena) begin
            wcount++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=0x%08h exp=none",
                         bus.term_addr, bus.term_wdata);
            end else begin
                e = sb.pop_front();
                if (bus.term_addr !== e[63:32] || bus.term_wdata !== e[31:0] ||
                    bus.term_rw !== 1'b1) begin
                    failures++;
                    $display("FAIL term_write got addr=%0d data=0x%08h rw=%b exp addr=%0d data=0x%08h rw=1",
                             bus.term_addr, bus.term_wdata, bus.term_rw, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ena   = 1'b1;
        bus.rw    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.ena   = 1'b0;
        bus.rw    = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        bus.addr = 32'h4;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (bus.rdata[0] == 1'b0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s busy_timeout got=busy exp=idle", name);
        end
    endtask

    task automatic push(input logic [7:0] b);
        cpu_write(32'h0, {24'b0, b});
    endtask

    logic [31:0] rd;
    int          base;
    bit          hit;

    initial begin
        rst       = 1'b0;
        bus.ena   = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state and quiet terminal port
        cpu_read(32'h4, rd); check("reset_status", rd, 32'h0);
        cpu_read(32'h8, rd); check("reset_cursor", rd, 32'h0);
        base = wcount;
        repeat (10) @(negedge clk);
        check("idle_no_writes", 32'(wcount), 32'(base));

        // Single printable: busy for exactly one cycle
        expect_wr(0, 8'h41);
        push(8'h41);
        bus.addr = 32'h4;
        @(negedge clk); #1; check("put_busy_n1", bus.rdata, 32'h1);
        @(negedge clk); #1; check("put_idle_n2", bus.rdata, 32'h0);
        cpu_read(32'h8, rd); check("cursor_after_A", rd, 32'h0000_0001);

        // Full row of 0x42 from (0,0) wraps and clears row 1
        cpu_write(32'h8, 32'h0);
        for (int i = 0; i < 70; i++) begin
            expect_wr(i, 8'h42);
            if (i == 69) for (int j = 0; j < 70; j++) expect_wr(70 + j, 8'h20);
            push(8'h42);
            wait_idle("row_fill");
        end
        cpu_read(32'h8, rd); check("cursor_after_row", rd, 32'h0001_0000);

        // LF on the last row wraps to row 0; busy spans 70 cycles
        cpu_write(32'h8, 32'h001D_0005);
        cpu_read(32'h8, rd); check("cursor_29_5", rd, 32'h001D_0005);
        for (int j = 0; j < 70; j++) expect_wr(j, 8'h20);
        push(8'h0A);
        bus.addr = 32'h4;
        for (int k = 1; k <= 71; k++) begin
            @(negedge clk); #1;
            if (k == 70) check("lf_busy_c70", bus.rdata, 32'h1);
            if (k == 71) check("lf_idle_c71", bus.rdata, 32'h0);
        end
        cpu_read(32'h8, rd); check("cursor_after_lf_wrap", rd, 32'h0);

        // Clamped cursor load, printable in the last cell wraps to row 0
        cpu_write(32'h8, 32'h001F_007F);
        cpu_read(32'h8, rd); check("cursor_clamp", rd, 32'h001D_0045);
        expect_wr(2099, 8'h43);
        for (int j = 0; j < 70; j++) expect_wr(j, 8'h20);
        push(8'h43);
        wait_idle("last_cell");
        cpu_read(32'h8, rd); check("cursor_after_last_cell", rd, 32'h0);

        // CR, BS at column 0, BS, ignored byte
        cpu_write(32'h8, 32'h0002_000A);
        push(8'h0D);
        repeat (3) @(negedge clk);
        cpu_read(32'h8, rd); check("cursor_after_cr", rd, 32'h0002_0000);
        push(8'h08);
        repeat (3) @(negedge clk);
        cpu_read(32'h8, rd); check("cursor_bs_col0", rd, 32'h0002_0000);
        cpu_write(32'h8, 32'h0002_000A);
        expect_wr(149, 8'h20);
        push(8'h08);
        wait_idle("bs");
        cpu_read(32'h8, rd); check("cursor_after_bs", rd, 32'h0002_0009);
        push(8'h07);
        repeat (3) @(negedge clk);
        cpu_read(32'h8, rd); check("cursor_after_ignored", rd, 32'h0002_0009);

        // Push while busy is dropped and flags overflow
        for (int j = 0; j < 70; j++) expect_wr(210 + j, 8'h20);
        push(8'h0A);
        push(8'h41);
        cpu_read(32'h4, rd); check("status_ovf_busy", rd, 32'h3);
        wait_idle("lf_ovf");
        cpu_read(32'h4, rd); check("status_ovf_idle", rd, 32'h2);
        cpu_read(32'h8, rd); check("cursor_after_lf", rd, 32'h0003_0000);
        cpu_write(32'h4, 32'h0);
        cpu_read(32'h4, rd); check("status_cleared", rd, 32'h0);
        check("sb_drained", 32'(sb.size()), 32'h0);

        // Screen clear aborted by reset at the 1000th write
        for (int j = 0; j < 2100; j++) expect_wr(j, 8'h20);
        base = wcount;
        cpu_write(32'hC, 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 1200 && !hit; i++) begin
            @(negedge clk); #2;
            if (wcount - base >= 1000) hit = 1'b1;
        end
        check("clear_reached_1000", 32'(hit), 32'h1);
        check("clear_write_count", 32'(wcount - base), 32'd1000);
        rst = 1'b0;
        #1;
        check("rst_term_ena_async", 32'(bus.term_ena), 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        cpu_read(32'h8, rd); check("cursor_after_abort", rd, 32'h0);
        cpu_read(32'h4, rd); check("status_after_abort", rd, 32'h0);
        base = wcount;
        repeat (5) @(negedge clk);
        check("no_resume", 32'(wcount), 32'(base));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
